// File: rtl/led_seq_pkg.sv
// Shared mode and direction encodings for the LED pattern sequencer family.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: raises terminal once every TICK_DIV enabled cycles.
// Dropping en clears the count so a resumed run always gets a full period.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic terminal
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last   = (r_count == LAST);
    assign terminal = en & w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!en || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: rotate-left/right, bounce and hold, stepped by an internal
// prescaler while enabled or by step_req rising edges while paused.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int                  LED_BITS     = 4,
    parameter int                  TICK_DIV     = 100_000_000,
    parameter logic [LED_BITS-1:0] INIT_PATTERN = LED_BITS'(1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                step_req,
    output logic [LED_BITS-1:0] led,
    output logic                tick,
    output logic                dir
);

    logic [LED_BITS-1:0] r_led;
    logic                r_tick;
    logic                r_dir;
    logic                r_step_q;
    logic [1:0]          r_mode_q;

    logic                w_entry;
    logic                w_pre_en;
    logic                w_terminal;
    logic                w_step;
    logic [LED_BITS-1:0] w_led_nxt;
    logic                w_dir_nxt;

    assign w_entry = (mode == MODE_BOUNCE) && (r_mode_q != MODE_BOUNCE);

    // Holding the prescaler disabled for the entry cycle restarts its period.
    assign w_pre_en = en & ~w_entry;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (w_pre_en),
        .terminal (w_terminal)
    );

    assign w_step = (en & w_terminal) | (~en & step_req & ~r_step_q);

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        case (mode)
            MODE_ROT_L: w_led_nxt = {r_led[LED_BITS-2:0], r_led[LED_BITS-1]};
            MODE_ROT_R: w_led_nxt = {r_led[0], r_led[LED_BITS-1:1]};
            MODE_BOUNCE: begin
                if (r_dir == DIR_LEFT) begin
                    if (r_led[LED_BITS-1]) begin
                        w_led_nxt = r_led >> 1;
                        w_dir_nxt = DIR_RIGHT;
                    end else begin
                        w_led_nxt = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_led_nxt = r_led << 1;
                        w_dir_nxt = DIR_LEFT;
                    end else begin
                        w_led_nxt = r_led >> 1;
                    end
                end
            end
            default: w_led_nxt = r_led;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led    <= INIT_PATTERN;
            r_tick   <= 1'b0;
            r_dir    <= DIR_LEFT;
            r_step_q <= 1'b0;
            r_mode_q <= MODE_ROT_L;
        end else begin
            r_step_q <= step_req;
            r_mode_q <= mode;
            if (w_entry) begin
                r_led  <= LED_BITS'(1);
                r_dir  <= DIR_LEFT;
                r_tick <= 1'b0;
            end else if (w_step) begin
                r_led  <= w_led_nxt;
                r_dir  <= w_dir_nxt;
                r_tick <= 1'b1;
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign led  = r_led;
    assign tick = r_tick;
    assign dir  = r_dir;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised LED pattern engine, the next generation of the fixed 4-bit rotating LED register. It has an integral prescaler, so no external step pulse is needed. It supports selectable rotate-left, rotate-right, bounce and hold modes, plus a single-step input for use while paused. It sits directly behind the board clock tree and drives the LED pins, or any status-indicator bus, from a single clock domain.

Parameters:
LED_BITS, 4, width of LED bus; legal range >= 2
TICK_DIV, 100_000_000, clock cycles per pattern step (1 s at 100 MHz); legal range >= 1
INIT_PATTERN, 4'b0001 (LED_BITS wide), reset/load pattern; must be nonzero

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
en  input  1  1 = free-run on prescaler ticks; 0 = paused
mode  input  2  00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 HOLD
step_req  input  1  manual step; rising edge honoured only while en=0
led  output  LED_BITS  current pattern, registered
tick  output  1  one-cycle pulse, registered, high in the cycle led takes a step value
dir  output  1  bounce direction: 0 = moving left (toward MSB), 1 = moving right; registered

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). All state is cleared on assertion, and the first update occurs on the first clk edge after deassertion.
- Reset values:
  - led = INIT_PATTERN
  - tick = 0
  - dir = 0
  - prescaler count = 0
  - step_req_q = 0
  - mode_q = 00
- Prescaler:
  - count width = max(1, clog2(TICK_DIV)).
  - While en=1, count increments. At count == TICK_DIV-1 it raises the internal terminal flag and wraps to 0.
  - While en=0, count is forced to 0, so resuming gives a full period.
  - TICK_DIV=1 gives a terminal flag every enabled cycle.
- Step event, combinational:
  - step = (en & terminal) | (~en & step_req & ~step_req_q).
  - step_req_q is step_req registered every cycle.
- Latency: on the clk edge at which step is true, led takes its next value and tick is set to 1. tick clears on the next edge unless another step occurs.
- Next value per mode:
  - ROT_L: {led[N-2:0], led[N-1]}.
  - ROT_R: {led[0], led[N-1:1]}.
  - HOLD: led unchanged; tick still pulses.
  - BOUNCE, dir=0: if led[N-1] then logical shift right and dir<=1; else logical shift left.
  - BOUNCE, dir=1: if led[0] then logical shift left and dir<=0; else logical shift right.
  - The endpoint is shown once per bounce (N=4: 0001,0010,0100,1000,0100,0010,0001,0010...).
- Mode change:
  - mode_q registers mode every cycle.
  - Entry into BOUNCE (mode==10 & mode_q!=10) loads led = 1 (LSB only), dir = 0, count = 0, tick = 0.
  - Entry has priority over a coincident step; that step is discarded.
  - All other mode changes preserve led and count. dir is held while not in BOUNCE.
  - If mode=10 at reset release, the entry load occurs on the first edge.
- Changing en mid-period discards the partial count.
- A step_req edge while en=1 is ignored and is not queued.
- A step_req held high gives exactly one step.

Decomposition:
- Package led_seq_pkg holds:
  - mode constants MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, tick_prescaler, contains:
  - parameter TICK_DIV;
  - ports clk, reset, en, terminal;
  - the counter with clear-on-disable.
- It is reusable by other blinkers and heartbeat blocks.
- Pattern/direction logic stays in led_pattern_sequencer.

Test Plan:
1. Reset mid-run: assert reset asynchronously between edges -> led=0001, tick=0, dir=0 immediately, without waiting for a clock edge; first tick 4 cycles after release (TICK_DIV=4).
2. ROT_L, en=1, TICK_DIV=4, LED_BITS=4 -> led 0001,0010,0100,1000,0001 with updates every 4 cycles; tick high exactly one cycle per update.
3. ROT_R from 0001 -> 1000,0100,0010,0001. Switch to HOLD mid-period -> led frozen, tick continues every 4 cycles, count not reset.
4. BOUNCE entry on the same cycle as a terminal count -> led=0001, no tick that cycle. Then 0010,0100,1000,0100,0010,0001,0010; dir toggles on the 1000->0100 and 0001->0010 steps.
5. en=0, step_req held high 10 cycles, then low, then high again -> exactly two steps, each 1 cycle after the rising edge. With en=1, step_req pulses -> no extra steps.
6. TICK_DIV=1, LED_BITS=8, INIT_PATTERN=8'b1000_0001, ROT_L -> step every cycle: 00000011, 00000110, ...; toggle en low for 3 cycles -> no steps, resumes next enabled cycle.
